// File: rtl/bus_cache.sv
// Direct-mapped, read-only instruction cache with 64-byte lines. A miss fetches
// the whole line as an 8-beat Sysbus read; hits return the word combinationally.
module bus_cache #(
    parameter int BUS_DATA_WIDTH   = 64,
    parameter int BUS_TAG_WIDTH    = 13,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int LINES            = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        instruction_read,
    input  logic [INSTRUCTION_SIZE-1:0] instruction_address,
    output logic [INSTRUCTION_SIZE-1:0] instruction_response,
    output logic                        busy,
    input  logic                        mem_read,
    input  logic                        mem_write,
    output logic                        bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    input  logic                        bus_reqack,
    input  logic                        bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    output logic                        bus_respack
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = INSTRUCTION_SIZE - 6 - IDX_W;
    localparam logic [BUS_TAG_WIDTH-1:0] READ_MEM_TAG = BUS_TAG_WIDTH'(13'h1100);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                      state_q, state_d;
    logic [INSTRUCTION_SIZE-1:0] lineAddr_q, lineAddr_d;
    logic [2:0]                  beat_q, beat_d;
    logic [LINES-1:0]            valid_q;
    logic [TAG_W-1:0]            tag_q [LINES];
    logic [BUS_DATA_WIDTH-1:0]   data_q [LINES*8];

    logic [IDX_W-1:0]            reqIdx, fillIdx;
    logic [TAG_W-1:0]            reqTag, fillTag;
    logic [BUS_DATA_WIDTH-1:0]   hitWord;
    logic                        hit, beatAccept, fillDone;
    logic                        unusedInputs;

    assign reqIdx     = instruction_address[6+IDX_W-1:6];
    assign reqTag     = instruction_address[INSTRUCTION_SIZE-1:6+IDX_W];
    assign fillIdx    = lineAddr_q[6+IDX_W-1:6];
    assign fillTag    = lineAddr_q[INSTRUCTION_SIZE-1:6+IDX_W];
    assign hit        = valid_q[reqIdx] && (tag_q[reqIdx] == reqTag);
    assign hitWord    = data_q[{reqIdx, instruction_address[5:3]}];
    assign beatAccept = reset && (state_q == RESP) && bus_respcyc;
    assign fillDone   = beatAccept && (beat_q == 3'd7);

    // Reserved data-path strobes, response tag and the byte-in-word bits carry no meaning here.
    assign unusedInputs = ^{mem_read, mem_write, bus_resptag, instruction_address[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            lineAddr_q <= '0;
            beat_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            lineAddr_q <= lineAddr_d;
            beat_q     <= beat_d;
            if (fillDone) begin
                valid_q[fillIdx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beatAccept) begin
            data_q[{fillIdx, beat_q}] <= bus_resp;
        end
        if (fillDone) begin
            tag_q[fillIdx] <= fillTag;
        end
    end

    always_comb begin
        state_d    = state_q;
        lineAddr_d = lineAddr_q;
        beat_d     = beat_q;
        case (state_q)
            IDLE: begin
                if (instruction_read && !hit) begin
                    state_d    = REQ;
                    lineAddr_d = {instruction_address[INSTRUCTION_SIZE-1:6], 6'b0};
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    state_d = RESP;
                    beat_d  = '0;
                end
            end
            RESP: begin
                // The counter wraps back to 0 exactly when the last beat leaves RESP.
                if (bus_respcyc) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instruction_response = '0;
        busy                 = 1'b0;
        bus_reqcyc           = 1'b0;
        bus_req              = '0;
        bus_reqtag           = '0;
        bus_respack          = 1'b0;
        case (state_q)
            IDLE: begin
                if (instruction_read) begin
                    busy = !hit;
                    if (hit) begin
                        instruction_response = instruction_address[2]
                            ? hitWord[2*INSTRUCTION_SIZE-1:INSTRUCTION_SIZE]
                            : hitWord[INSTRUCTION_SIZE-1:0];
                    end
                end
            end
            REQ: begin
                busy = 1'b1;
                if (reset) begin
                    bus_reqcyc = 1'b1;
                    bus_req    = BUS_DATA_WIDTH'(lineAddr_q);
                    bus_reqtag = READ_MEM_TAG;
                end
            end
            RESP: begin
                busy        = 1'b1;
                bus_respack = bus_respcyc && reset;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_cache.sv
// Scoreboard bench for bus_cache: the bench plays the Sysbus memory and predicts
// fetch results and line requests from a line-level model of the cache contents.
module tb_bus_cache;
    localparam logic [12:0] READ_MEM_TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instruction_read = 1'b0;
    logic [31:0] instruction_address = '0;
    logic [31:0] instruction_response;
    logic        busy;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;

    bus_cache dut (
        .clk(clk), .reset(reset),
        .instruction_read(instruction_read), .instruction_address(instruction_address),
        .instruction_response(instruction_response), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    bit          modelValid [64];
    logic [19:0] modelTag [64];
    logic [63:0] modelData [64][8];
    logic [31:0] respQ [$];
    logic [63:0] reqQ [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        prevReqcyc = 1'b0;
    logic [31:0] monExpWord;
    logic [63:0] monExpAddr;

    function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    function automatic bit modelHit(logic [31:0] a);
        return modelValid[a[11:6]] && (modelTag[a[11:6]] == a[31:12]);
    endfunction

    function automatic logic [31:0] modelWord(logic [31:0] a);
        logic [63:0] d;
        d = modelData[a[11:6]][a[5:3]];
        return a[2] ? d[63:32] : d[31:0];
    endfunction

    // Monitor: every valid fetch result and every new bus request is matched against the queues.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (instruction_read && busy === 1'b0) begin
                if (respQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected response: got 0x%0h, expected none at %0t", instruction_response, $time);
                end else begin
                    monExpWord = respQ.pop_front();
                    checkOutput("fetch data", 64'(instruction_response), 64'(monExpWord));
                end
            end
            if (bus_reqcyc === 1'b1 && !prevReqcyc) begin
                if (reqQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected request: got 0x%0h, expected none at %0t", bus_req, $time);
                end else begin
                    monExpAddr = reqQ.pop_front();
                    checkOutput("request address", bus_req, monExpAddr);
                    checkOutput("request tag", 64'(bus_reqtag), 64'(READ_MEM_TAG));
                end
            end
        end
        prevReqcyc <= (bus_reqcyc === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic directedHit(input logic [31:0] addr, input logic [31:0] expected);
        instruction_read = 1'b1;
        instruction_address = addr;
        respQ.push_back(expected);
        tick();
    endtask

    task automatic idleCycle();
        instruction_read = 1'b0;
        instruction_address = $urandom;
        #2;
        checkOutput("idle busy", 64'(busy), 64'd0);
        checkOutput("idle response", 64'(instruction_response), 64'd0);
        tick();
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int ackDelay, input int gap,
                                 input int abortAfter, input bit directed);
        logic [31:0] line;
        logic [63:0] beats [8];
        int          waitCycles;
        line = {addr[31:6], 6'b0};
        instruction_read = 1'b1;
        instruction_address = addr;
        if (modelHit(addr)) begin
            respQ.push_back(modelWord(addr));
            tick();
            return;
        end
        reqQ.push_back(64'(line));
        tick();
        waitCycles = 0;
        while (bus_reqcyc !== 1'b1 && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        if (bus_reqcyc !== 1'b1) begin
            checkOutput("request timeout", 64'(bus_reqcyc), 64'd1);
            return;
        end
        // Address wandering during the fill must not disturb the line being fetched.
        for (int c = 0; c < ackDelay; c++) begin
            instruction_address = $urandom;
            #2;
            checkOutput("held reqcyc", 64'(bus_reqcyc), 64'd1);
            checkOutput("held request address", bus_req, 64'(line));
            checkOutput("held request tag", 64'(bus_reqtag), 64'(READ_MEM_TAG));
            tick();
        end
        bus_reqack = 1'b1;
        #2;
        checkOutput("reqcyc at ack", 64'(bus_reqcyc), 64'd1);
        tick();
        bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'b0;
                instruction_address = $urandom;
                #2;
                checkOutput("respack in gap", 64'(bus_respack), 64'd0);
                checkOutput("reqcyc in resp", 64'(bus_reqcyc), 64'd0);
                checkOutput("busy in fill", 64'(busy), 64'd1);
                tick();
            end
            if (k == abortAfter) begin
                instruction_read = 1'b0;
                reset = 1'b0;
                bus_respcyc = 1'b1;
                bus_resp = {$urandom, $urandom};
                #2;
                checkOutput("respack while in reset", 64'(bus_respack), 64'd0);
                tick();
                reset = 1'b1;
                #2;
                checkOutput("respack after abort", 64'(bus_respack), 64'd0);
                checkOutput("busy after abort", 64'(busy), 64'd0);
                tick();
                bus_respcyc = 1'b0;
                foreach (modelValid[i]) modelValid[i] = 1'b0;
                return;
            end
            beats[k] = directed ? (64'h11111111_00000000 + 64'(k)) : {$urandom, $urandom};
            bus_respcyc = 1'b1;
            bus_resp = beats[k];
            #2;
            checkOutput("respack on beat", 64'(bus_respack), 64'd1);
            checkOutput("busy on beat", 64'(busy), 64'd1);
            tick();
        end
        bus_respcyc = 1'b0;
        instruction_address = addr;
        modelValid[line[11:6]] = 1'b1;
        modelTag[line[11:6]] = line[31:12];
        for (int k = 0; k < 8; k++) modelData[line[11:6]][k] = beats[k];
        respQ.push_back(modelWord(addr));
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b0;
        instruction_read = 1'b1;
        instruction_address = 32'h1000;
        bus_respcyc = 1'b1;
        repeat (2) tick();
        #2;
        checkOutput("reqcyc in reset", 64'(bus_reqcyc), 64'd0);
        checkOutput("respack in reset", 64'(bus_respack), 64'd0);
        checkOutput("request address in reset", bus_req, 64'd0);
        checkOutput("request tag in reset", 64'(bus_reqtag), 64'd0);
        bus_respcyc = 1'b0;
        reset = 1'b1;

        applyStimulus(32'h1000, 0, 0, -1, 1'b1);
        directedHit(32'h1004, 32'h11111111);
        directedHit(32'h1038, 32'h00000007);
        directedHit(32'h1000, 32'h00000000);
        idleCycle();

        applyStimulus(32'h2000, 5, 2, -1, 1'b0);
        applyStimulus(32'h1000, 0, 0, -1, 1'b1);
        directedHit(32'h103c, 32'h11111111);
        idleCycle();

        applyStimulus(32'h3000, 1, 0, 3, 1'b0);
        idleCycle();
        applyStimulus(32'h3000, 0, 1, -1, 1'b0);
        applyStimulus(32'h3008, 0, 0, -1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 3) * 32'h0004_1000) | ($urandom_range(0, 3) << 6) | ($urandom & 32'h3f);
            if ($urandom_range(0, 7) == 0) idleCycle();
            else applyStimulus(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, 1'b0);
        end

        instruction_read = 1'b0;
        tick();
        checkOutput("pending responses", 64'(respQ.size()), 64'd0);
        checkOutput("pending requests", 64'(reqQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
